product_display_ctrl: RTL
=========================

Name: product_display_ctrl

Overview:
- Sequencing controller between the signed 8x8 serial-parallel multiplier and the 4-digit common-anode 7-segment display.
- Accepts a 16-bit signed product on a load strobe and converts its magnitude to 5 BCD digits with a one-bit-per-cycle double-dabble FSM.
- Time-multiplexes the sign and the digits across the four anodes with leading-zero blanking and a two-position digit window.
- Segment patterns for 0-9 match the team's existing a-to-g decoder encoding.

Parameters:
- REFRESH_DIV, 100000, clock cycles each anode stays active; legal values are 2 or more.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- product  input  16  signed two's-complement product from the multiplier.
- load  input  1  one-cycle strobe; captures product when not busy.
- window  input  1  0 = show d2..d0, 1 = show d4..d3.
- busy  output  1  high while a conversion is in progress.
- ready  output  1  one-cycle pulse when new digits are latched into the display.
- seg  output  7  segments a..g, active-low, bit6 = a, bit0 = g.
- an  output  4  anode enables, active-low, an[3] = leftmost.

Behaviour:
- Interface: one clock, clk; asynchronous active-high reset, rst.
- Reset values:
  - state IDLE, busy=0, ready=0.
  - display registers: neg=0, d4..d0 = 0.
  - scan counter = 0, digit index = 0.
  - an=4'b1110, seg=7'b0000001.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - load=1: capture neg = product[15] and mag = |product| as 16-bit unsigned (-32768 gives 32768).
  - Clear the 20-bit BCD accumulator, set busy=1, go to CONV.
- CONV:
  - One double-dabble iteration per cycle: add 3 to each BCD nibble >= 5, then shift left taking mag MSB.
  - 16 iterations, tracked by a 4-bit counter.
  - After the 16th iteration, go to DONE.
- DONE (single cycle):
  - Copy BCD to d4..d0 and neg into the display registers.
  - ready=1 for this cycle, busy=0 from the next cycle, return to IDLE.
- Latency: load sampled at edge N gives ready high in cycle N+17 and the new digits displayed from N+18.
- load during CONV or DONE is ignored; the captured operand is unaffected. No queuing.
- The display shows the previous value for the whole conversion.
- Scan:
  - Counter runs 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit index advances 0->1->2->3->0.
  - Index i drives an[i] low, all others high.
  - an and seg are registered and update together on the cycle after the wrap.
  - Scan runs continuously, independent of FSM state.
- Position mapping:
  - window=0: an[3]=sign, an[2]=d2, an[1]=d1, an[0]=d0.
  - window=1: an[3]=sign, an[2]=blank, an[1]=d4, an[0]=d3.
- Sign: '-' = 7'b1111110 when neg=1 and magnitude != 0; otherwise blank = 7'b1111111.
- Leading-zero blanking: digit dk (k>0) is blank when dk..d4 are all zero. d0 is always shown.
- Digit codes 0-9:
  - 0000001, 1001111, 0010010, 0000110, 1001100
  - 0100100, 0100000, 0001111, 0000000, 0000100
- A window change takes effect at the next registered update of seg, with no reset of the scan.
- rst asserted mid-conversion aborts it: all state returns to reset values and the display shows 0.

Test Plan:
- Reset, REFRESH_DIV=4 -> an=1110, seg=0000001, busy=0, ready=0; an steps 1101, 1011, 0111 every 4 cycles; an[3] seg=1111111.
- load product=16'h4000 (16384) -> busy high 17 cycles, ready pulse at N+17. window=0: an[2]=0000110, an[1]=0000000, an[0]=1001100. window=1: an[1]=1001111, an[0]=0100000, an[2] blank.
- load product=16'hFFD6 (-42), window=0 -> an[3]=1111110, an[2]=1111111, an[1]=1001100, an[0]=0010010. window=1: an[1] and an[0] blank.
- load product=16'h8000 (-32768) -> window=1: an[1]=0000110 ('3'), an[0]=0010010 ('2'). window=0: '7', '6', '8'. Sign '-'.
- load 16'h0005, then load 16'h0009 while busy -> second strobe ignored; display shows '5' only, single ready pulse.
- Assert rst at CONV iteration 8 after loading 16'h1234 -> busy=0 immediately; ready never pulses; display shows 0 and an=1110.

Source files
------------

// File: rtl/product_display_ctrl.sv
// Converts a signed 16-bit product to BCD with a one-bit-per-cycle double-dabble
// FSM and scans the sign plus a two-position digit window across a 4-digit display.
module product_display_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] product,
    input  logic               load,
    input  logic               window,
    output logic               busy,
    output logic               ready,
    output logic [6:0]         seg,
    output logic [3:0]         an
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b1111110;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t        state;
    logic          neg_cap;
    logic [15:0]   mag;
    logic [19:0]   bcd;
    logic [19:0]   bcd_adj;
    logic [3:0]    iter;
    logic          neg;
    logic [3:0]    d0, d1, d2, d3, d4;
    logic [CW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;

    // -32768 has no positive 16-bit signed counterpart, so the result is unsigned.
    function automatic logic [15:0] magnitude(input logic signed [15:0] v);
        logic [15:0] u;
        u = $unsigned(v);
        return v[15] ? (~u + 16'd1) : u;
    endfunction

    function automatic logic [19:0] dabble_adjust(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int k = 0; k < 5; k++) begin
            if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] digit_code(input logic [3:0] d);
        case (d)
            4'd0:    digit_code = 7'b0000001;
            4'd1:    digit_code = 7'b1001111;
            4'd2:    digit_code = 7'b0010010;
            4'd3:    digit_code = 7'b0000110;
            4'd4:    digit_code = 7'b1001100;
            4'd5:    digit_code = 7'b0100100;
            4'd6:    digit_code = 7'b0100000;
            4'd7:    digit_code = 7'b0001111;
            4'd8:    digit_code = 7'b0000000;
            4'd9:    digit_code = 7'b0000100;
            default: digit_code = BLANK;
        endcase
    endfunction

    assign bcd_adj = dabble_adjust(bcd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            ready   <= 1'b0;
            neg_cap <= 1'b0;
            mag     <= '0;
            bcd     <= '0;
            iter    <= '0;
            neg     <= 1'b0;
            d0      <= '0;
            d1      <= '0;
            d2      <= '0;
            d3      <= '0;
            d4      <= '0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        neg_cap <= product[15];
                        mag     <= magnitude(product);
                        bcd     <= '0;
                        iter    <= '0;
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    bcd  <= {bcd_adj[18:0], mag[15]};
                    mag  <= {mag[14:0], 1'b0};
                    iter <= iter + 4'd1;
                    if (iter == 4'd15) state <= DONE;
                end
                DONE: begin
                    d0    <= bcd[3:0];
                    d1    <= bcd[7:4];
                    d2    <= bcd[11:8];
                    d3    <= bcd[15:12];
                    d4    <= bcd[19:16];
                    neg   <= neg_cap;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A digit is blanked when it and every more significant digit are zero.
    always_comb begin
        seg_next = BLANK;
        case (idx)
            2'd3: seg_next = (neg && (|{d4, d3, d2, d1, d0})) ? MINUS : BLANK;
            2'd2: seg_next = (!window && (|{d4, d3, d2})) ? digit_code(d2) : BLANK;
            2'd1: begin
                if (window) seg_next = (|d4) ? digit_code(d4) : BLANK;
                else        seg_next = (|{d4, d3, d2, d1}) ? digit_code(d1) : BLANK;
            end
            default: begin
                if (window) seg_next = (|{d4, d3}) ? digit_code(d3) : BLANK;
                else        seg_next = digit_code(d0);
            end
        endcase
        an_next = ~(4'b0001 << idx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            an       <= 4'b1110;
            seg      <= 7'b0000001;
        end else begin
            if (scan_cnt == CW'(REFRESH_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + CW'(1);
            end
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule
